// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with programmable wait states
// One access outstanding at a time; the response is held until the requester takes it.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          lat_write;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          acc_go;
   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic          acc_err;
   logic [AW-1:0] acc_idx;

   // With zero wait states the access happens on the accept edge, so it must use the live request.
   always_comb begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_go    = (state == S_WAIT) && (cnt == '0);
      if (state == S_IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_go    = req_valid && (WAIT_CYCLES == 0);
      end
   end

   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_LIM);
   assign acc_idx = acc_addr[AW+1:2];

   // Memory contents survive reset; an edge seen while reset is high never writes.
   always_ff @(posedge clk) begin
      if (!rst && acc_go && acc_write && !acc_err) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  state      <= S_IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (acc_go) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'h0;
         end
      end
   end

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed check of dmem_responder against a behavioural model
// Two builds share one stimulus bus: instance 0 with two wait states, instance 1 with none.
module tb_dmem_responder;
   localparam int NI = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_ready;

   logic [1:0]       rdy;
   logic [1:0]       vld;
   logic [1:0]       er;
   logic [1:0]       bsy;
   logic [1:0][31:0] rd;

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // Behavioural model: per instance, one outstanding access and edges elapsed since acceptance.
   bit          m_out   [NI];
   int          m_since [NI];
   bit          m_write [NI];
   logic [31:0] m_addr  [NI];
   logic [31:0] m_wdata [NI];
   logic [31:0] m_rdata [NI];
   bit          m_err   [NI];
   bit          m_known [NI];
   logic [31:0] mem_m   [NI][256];
   bit          wr_m    [NI][256];

   int          bcount  [NI];
   int          hs_cnt  [NI];
   logic [31:0] last_rd [NI];
   logic        last_er [NI];

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(vld[0]), .resp_ready(resp_ready), .resp_rdata(rd[0]),
      .resp_err(er[0]), .busy(bsy[0])
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(vld[1]), .resp_ready(resp_ready), .resp_rdata(rd[1]),
      .resp_err(er[1]), .busy(bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wc(int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", name, i, act, exp, $time);
      end
   endtask

   task automatic commit(int i);
      int w;
      w = int'(m_addr[i] / 4);
      m_err[i] = (m_addr[i] % 4 != 0) || (m_addr[i] / 4 >= 256);
      m_rdata[i] = 32'h0;
      m_known[i] = 1'b1;
      if (!m_err[i]) begin
         if (m_write[i]) begin
            mem_m[i][w] = m_wdata[i];
            wr_m[i][w]  = 1'b1;
         end else begin
            m_rdata[i] = mem_m[i][w];
            m_known[i] = wr_m[i][w];
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            if (m_out[i]) begin
               if (m_since[i] >= wc(i)) begin
                  if (resp_ready) m_out[i] = 1'b0;
               end else begin
                  m_since[i]++;
                  if (m_since[i] == wc(i)) commit(i);
               end
            end else if (req_valid) begin
               m_out[i]   = 1'b1;
               m_since[i] = 0;
               m_write[i] = req_write;
               m_addr[i]  = req_addr;
               m_wdata[i] = req_wdata;
               if (wc(i) == 0) commit(i);
            end
         end
      end
   end

   always @(negedge clk) begin
      bit ev;
      if (!rst && chk_en) begin
         for (int i = 0; i < NI; i++) begin
            ev = m_out[i] && (m_since[i] >= wc(i));
            chk("req_ready", i, 32'(rdy[i]), 32'(!m_out[i]));
            chk("busy", i, 32'(bsy[i]), 32'(m_out[i]));
            chk("resp_valid", i, 32'(vld[i]), 32'(ev));
            if (!ev) begin
               chk("idle_rdata", i, rd[i], 32'h0);
               chk("idle_err", i, 32'(er[i]), 32'h0);
            end else begin
               chk("resp_err", i, 32'(er[i]), 32'(m_err[i]));
               if (m_known[i]) chk("resp_rdata", i, rd[i], m_rdata[i]);
            end
            if (bsy[i]) bcount[i]++;
            if (vld[i] && resp_ready) begin
               hs_cnt[i]++;
               last_rd[i] = rd[i];
               last_er[i] = er[i];
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         m_out[i] = 1'b0;
         chk("rst_req_ready", i, 32'(rdy[i]), 32'h1);
         chk("rst_busy", i, 32'(bsy[i]), 32'h0);
         chk("rst_resp_valid", i, 32'(vld[i]), 32'h0);
         chk("rst_rdata", i, rd[i], 32'h0);
         chk("rst_err", i, 32'(er[i]), 32'h0);
      end
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (bsy != 2'b00 && n < 50) begin
         tick;
         n++;
      end
      chk(name, 0, 32'(bsy), 32'h0);
   endtask

   // One request presented to both instances while idle; hold>0 stalls the response that many cycles.
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output int b0, output int b1);
      int s0, s1, n;
      s0 = bcount[0];
      s1 = bcount[1];
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      resp_ready = (hold == 0);
      tick;
      req_valid = 1'b0;
      if (hold > 0) begin
         n = 0;
         while (!vld[0] && n < 50) begin
            tick;
            n++;
         end
         chk("wait_valid", 0, 32'(vld[0]), 32'h1);
         for (int k = 0; k < hold; k++) begin
            req_valid = $urandom_range(0, 1);
            req_addr  = $urandom_range(0, 63) * 4;
            req_write = $urandom_range(0, 1);
            tick;
         end
         req_valid  = 1'b0;
         resp_ready = 1'b1;
      end
      wait_idle("issue_timeout");
      b0 = bcount[0] - s0;
      b1 = bcount[1] - s1;
   endtask

   int b0, b1, h0, h1;

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      for (int i = 0; i < NI; i++) begin
         bcount[i] = 0; hs_cnt[i] = 0; m_out[i] = 1'b0;
         for (int k = 0; k < 256; k++) wr_m[i][k] = 1'b0;
      end
      #2;
      do_reset;
      chk_en = 1'b1;

      issue(1'b1, 32'h10, 32'hDEADBEEF, 0, b0, b1);
      chk("store_busy_cycles", 0, 32'(b0), 32'd3);
      chk("store_err", 0, 32'(last_er[0]), 32'h0);
      chk("store_rdata", 0, last_rd[0], 32'h0);

      issue(1'b0, 32'h10, 32'h0, 0, b0, b1);
      chk("load_rdata", 0, last_rd[0], 32'hDEADBEEF);
      chk("load_rdata", 1, last_rd[1], 32'hDEADBEEF);
      chk("load_busy_cycles", 0, 32'(b0), 32'd3);
      chk("load_busy_cycles", 1, 32'(b1), 32'd1);

      issue(1'b0, 32'h12, 32'h0, 0, b0, b1);
      chk("misaligned_err", 0, 32'(last_er[0]), 32'h1);
      chk("misaligned_rdata", 0, last_rd[0], 32'h0);
      issue(1'b0, 32'h400, 32'h0, 0, b0, b1);
      chk("range_err", 0, 32'(last_er[0]), 32'h1);
      chk("range_err", 1, 32'(last_er[1]), 32'h1);
      chk("range_rdata", 0, last_rd[0], 32'h0);
      issue(1'b0, 32'h3FC, 32'h0, 0, b0, b1);
      chk("last_word_err", 0, 32'(last_er[0]), 32'h0);
      issue(1'b0, 32'h10, 32'h0, 0, b0, b1);
      chk("reload_rdata", 0, last_rd[0], 32'hDEADBEEF);

      issue(1'b0, 32'h10, 32'h0, 5, b0, b1);
      chk("stall_rdata", 0, last_rd[0], 32'hDEADBEEF);
      chk("stall_busy_cycles", 0, 32'(b0), 32'd8);

      issue(1'b1, 32'h20, 32'hA5A50020, 0, b0, b1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; resp_ready = 1'b1;
      tick;
      req_valid = 1'b0;
      chk("in_wait_busy", 0, 32'(bsy[0]), 32'h1);
      chk("in_wait_valid", 0, 32'(vld[0]), 32'h0);
      do_reset;
      issue(1'b0, 32'h20, 32'h0, 0, b0, b1);
      chk("abort_no_write", 0, last_rd[0], 32'hA5A50020);
      chk("zero_wait_write", 1, last_rd[1], 32'h12345678);

      issue(1'b1, 32'h4, 32'hCAFEF00D, 0, b0, b1);
      issue(1'b0, 32'h4, 32'h0, 0, b0, b1);
      chk("w0_load_rdata", 1, last_rd[1], 32'hCAFEF00D);
      chk("w0_busy_cycles", 1, 32'(b1), 32'd1);

      h0 = hs_cnt[0];
      h1 = hs_cnt[1];
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) tick;
      req_valid = 1'b0;
      chk("b2b_handshakes", 0, 32'(hs_cnt[0] - h0), 32'd2);
      chk("b2b_handshakes", 1, 32'(hs_cnt[1] - h1), 32'd4);
      wait_idle("b2b_timeout");

      for (int c = 0; c < 3000; c++) begin
         req_valid  = ($urandom_range(0, 99) < 50);
         req_write  = $urandom_range(0, 1);
         req_wdata  = $urandom;
         resp_ready = ($urandom_range(0, 99) < 60);
         case ($urandom_range(0, 9))
            0:       req_addr = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
            1:       req_addr = 32'h400 + ($urandom_range(0, 63) * 4);
            2:       req_addr = 32'h3FC;
            default: req_addr = $urandom_range(0, 15) * 4;
         endcase
         tick;
         if (c == 1500) do_reset;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      wait_idle("drain_timeout");
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
